hdmi_clock_sequencer: RTL
=========================

# hdmi_clock_sequencer

Power-up and recovery sequencer for the HDMI clock chain: the rPLL that generates the 5x serial clock, the CLKDIV that produces the pixel clock, and the HDMI pixel-domain logic. It runs on the reference clock, holds the PLL in reset, qualifies PLL lock, and releases the divider reset and then the pixel-domain reset in order. On loss of lock or an explicit restart it tears the chain down and re-sequences. After a bounded number of lock timeouts it parks in a fault state.

## Interface
- RST_CYCLES, 16: cycles pll_reset is held per attempt (≥1)
- LOCK_TIMEOUT, 65535: max cycles waiting for lock per attempt (≥1)
- LOCK_STABLE, 1024: consecutive synced-lock cycles required before the divider is released (≥1)
- DIV_SETTLE, 8: cycles between clkdiv_resetn release and hdmi_rst release (≥1)
- MAX_RETRIES, 4: timeouts tolerated after the first attempt before FAULT
- CNT_W, 20: phase counter width; every count parameter must be ≤ 2^CNT_W−1
- clk  in  1  reference clock, the same clock that feeds the PLL
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  raw PLL lock, asynchronous to clk
- restart  in  1  single-cycle request to re-sequence from scratch
- pll_reset  out  1  PLL reset, active high
- clkdiv_resetn  out  1  CLKDIV RESETN, active low
- hdmi_rst  out  1  pixel-domain reset, active high; the consumer re-synchronises it
- ready  out  1  chain up and running
- lock_lost  out  1  sticky: lock dropped after the divider was released
- fault  out  1  retries exhausted
- retry_count  out  3  timeouts since the last RUN entry, restart or rst
- state  out  3  PLL_RST=0, WAIT_LOCK=1, STABLE=2, DIV_REL=3, RUN=4, FAULT=5

## Operation
- pll_lock passes through a 2-flop synchroniser to give lock_s. Both flops reset to 0.
- There is one phase counter. It clears on every state entry.
- State transitions:
  - PLL_RST: when counter == RST_CYCLES−1, go to WAIT_LOCK.
  - WAIT_LOCK: if lock_s=1, go to STABLE.
  - WAIT_LOCK timeout (counter == LOCK_TIMEOUT−1 with lock_s=0): if retry_count == MAX_RETRIES, go to FAULT. Otherwise increment retry_count and go to PLL_RST.
  - STABLE: if lock_s=0, go to WAIT_LOCK with a fresh timeout. If counter == LOCK_STABLE−1 with lock_s=1, go to DIV_REL.
  - DIV_REL: if lock_s=0, go to PLL_RST and set lock_lost. If counter == DIV_SETTLE−1, go to RUN.
  - RUN: retry_count clears to 0. If lock_s=0, go to PLL_RST and set lock_lost.
  - FAULT: terminal. Exit only via rst or restart.
- restart, from any state: go to PLL_RST; clear the counter, retry_count, lock_lost and fault. rst has priority over restart.
- Output decode, registered from next-state so outputs change on the same edge as state:
  - pll_reset=1 in PLL_RST and FAULT.
  - clkdiv_resetn=1 only in DIV_REL and RUN.
  - hdmi_rst=0 and ready=1 only in RUN.
  - fault=1 only in FAULT.
- Simultaneous events:
  - A lock drop on the same edge as a counter terminal count: the lock drop wins.
  - A timeout on the same edge that lock_s rises: the lock wins, and the state goes to STABLE.
- retry_count saturates at 7. It never wraps.

## Timing
- Reset values:
  - state=PLL_RST, counter=0.
  - pll_reset=1, clkdiv_resetn=0, hdmi_rst=1.
  - ready=0, lock_lost=0, fault=0, retry_count=0.
- Edge 1 is the first edge sampling rst=0.
- pll_lock to lock_s latency: 2 edges.
- With pll_lock high since before edge 1, ready rises on edge RST_CYCLES+1+LOCK_STABLE+DIV_SETTLE.
- Lock drop in RUN: ready falls, and hdmi_rst, pll_reset and lock_lost rise, exactly 3 edges after the pll_lock fall (2 sync + 1 register). clkdiv_resetn falls on the same edge.
- Ordering is guaranteed:
  - hdmi_rst never deasserts while clkdiv_resetn=0.
  - clkdiv_resetn never deasserts while pll_reset=1.
- rst asserted mid-sequence: all outputs return to their reset values on the next edge.

## Test plan
Parameters for all cases: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, DIV_SETTLE=3, MAX_RETRIES=2.

- **Clean bring-up.** pll_lock=1 throughout -> pll_reset falls at edge 4; clkdiv_resetn rises at edge 13; ready=1 and hdmi_rst=0 at edge 16; retry_count=0.
- **Lock glitch in STABLE.** Drop pll_lock for 1 cycle midway through STABLE -> state returns to WAIT_LOCK, then re-enters STABLE. ready is delayed by the glitch plus a full 8-cycle re-qualification; lock_lost stays 0.
- **Timeouts to fault.** pll_lock=0 throughout -> 32-cycle WAIT_LOCK windows; retry_count goes 1, then 2; the third timeout enters FAULT with fault=1 and pll_reset=1 held indefinitely.
- **Recovery from fault.** From FAULT, pulse restart, then raise pll_lock -> fault=0 and retry_count=0 on the next edge; ready=1 after 16 further edges.
- **Lock loss in RUN.** From RUN, drop pll_lock -> 3 edges later ready=0, hdmi_rst=1, clkdiv_resetn=0, pll_reset=1, lock_lost=1. Re-raise lock -> RUN again with lock_lost still 1.
- **Reset and restart mid-sequence.** Assert rst during DIV_REL -> all outputs at their reset values on the next edge. Assert restart and rst together -> same result.

Source files
------------

// File: rtl/hdmi_clock_sequencer.sv
// HDMI clock-chain power-up/recovery sequencer.
// Holds the rPLL in reset, qualifies a synchronised lock, then releases the CLKDIV reset
// and the pixel-domain reset in order. Tears the chain down on lock loss or restart and
// parks in FAULT after too many lock timeouts.
module hdmi_clock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned DIV_SETTLE   = 8,
    parameter int unsigned MAX_RETRIES  = 4,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_reset_o,
    output logic       clkdiv_resetn_o,
    output logic       hdmi_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic       fault_o,
    output logic [2:0] retry_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StDivRel   = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(DIV_SETTLE - 1);

    logic             lock_meta_q, lock_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic             lock_lost_q, lock_lost_d;
    logic             pll_reset_q, pll_reset_d;
    logic             clkdiv_resetn_q, clkdiv_resetn_d;
    logic             hdmi_rst_q, hdmi_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    // Two-flop synchroniser for the raw, asynchronous PLL lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State, phase counter, retry/sticky flags and registered output decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StPllRst;
            cnt_q           <= '0;
            retry_q         <= '0;
            lock_lost_q     <= 1'b0;
            pll_reset_q     <= 1'b1;
            clkdiv_resetn_q <= 1'b0;
            hdmi_rst_q      <= 1'b1;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            lock_lost_q     <= lock_lost_d;
            pll_reset_q     <= pll_reset_d;
            clkdiv_resetn_q <= clkdiv_resetn_d;
            hdmi_rst_q      <= hdmi_rst_d;
            ready_q         <= ready_d;
            fault_q         <= fault_d;
        end
    end

    // Next-state logic; lock checks sit ahead of terminal counts so a lock event wins ties.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;
        if (restart_i) begin
            state_d     = StPllRst;
            retry_d     = '0;
            lock_lost_d = 1'b0;
        end else begin
            case (state_q)
                StPllRst: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (lock_s_q) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        if (32'(retry_q) == MAX_RETRIES) begin
                            state_d = StFault;
                        end else begin
                            state_d = StPllRst;
                            if (retry_q != 3'd7) retry_d = retry_q + 3'd1;
                        end
                    end
                end
                StStable: begin
                    if (!lock_s_q) state_d = StWaitLock;
                    else if (cnt_q == StableLast) state_d = StDivRel;
                end
                StDivRel: begin
                    if (!lock_s_q) begin
                        state_d     = StPllRst;
                        lock_lost_d = 1'b1;
                    end else if (cnt_q == SettleLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lock_s_q) begin
                        state_d     = StPllRst;
                        lock_lost_d = 1'b1;
                    end
                end
                StFault: ;
                default: state_d = StPllRst;
            endcase
        end
        if (state_d == StRun) retry_d = '0;
        // Counter restarts on every state entry and on restart; it saturates rather than wraps.
        if (restart_i || (state_d != state_q)) cnt_d = '0;
        else if (cnt_q == '1)                  cnt_d = cnt_q;
        else                                   cnt_d = cnt_q + CNT_W'(1);
    end

    // Output decode from next state so outputs move on the same edge as state.
    always_comb begin
        pll_reset_d     = (state_d == StPllRst) || (state_d == StFault);
        clkdiv_resetn_d = (state_d == StDivRel) || (state_d == StRun);
        hdmi_rst_d      = (state_d != StRun);
        ready_d         = (state_d == StRun);
        fault_d         = (state_d == StFault);
    end

    assign pll_reset_o     = pll_reset_q;
    assign clkdiv_resetn_o = clkdiv_resetn_q;
    assign hdmi_rst_o      = hdmi_rst_q;
    assign ready_o         = ready_q;
    assign lock_lost_o     = lock_lost_q;
    assign fault_o         = fault_q;
    assign retry_count_o   = retry_q;
    assign state_o         = state_q;

endmodule
